// File: rtl/econ_run_seq.sv
// Run sequencer for a feed-forward accelerator: settles the weights, streams samples
// through one at a time and hands each result downstream, with a per-sample timeout.
//
// state | meaning
// IDLE  | waiting for start; done pulses here for one cycle after a run
// CFG   | weights valid, settling for CFG_CYCLES before the first sample
// LOAD  | ready for one upstream feature vector
// WAIT  | sample issued, waiting for the accelerator result (bounded)
// HOLD  | result presented downstream until accepted
module econ_run_seq #(
    parameter int IN_W       = 384,
    parameter int OUT_W      = 80,
    parameter int CFG_CYCLES = 2,
    parameter int TIMEOUT    = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [15:0]      num_samples,
    input  logic [IN_W-1:0]  s_dat,
    input  logic             s_vld,
    output logic             s_rdy,
    output logic [IN_W-1:0]  acc_in_dat,
    output logic             acc_in_vld,
    output logic             w_vld,
    input  logic [OUT_W-1:0] acc_out_dat,
    input  logic             acc_out_vld,
    output logic [OUT_W-1:0] m_dat,
    output logic             m_vld,
    input  logic             m_rdy,
    output logic             busy,
    output logic             done,
    output logic             timeout_err,
    output logic [15:0]      sample_cnt
);

    localparam int CW = (CFG_CYCLES > 1) ? $clog2(CFG_CYCLES) : 1;
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] CFG_LAST = CW'(CFG_CYCLES - 1);
    localparam logic [TW-1:0] TMR_LAST = TW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        CFG  = 3'd1,
        LOAD = 3'd2,
        WAIT = 3'd3,
        HOLD = 3'd4
    } state_t;

    state_t           state_q, state_d;
    logic [15:0]      num_q, num_d;
    logic [15:0]      cnt_q, cnt_d;
    logic [CW-1:0]    cfg_cnt_q, cfg_cnt_d;
    logic [TW-1:0]    tmr_q, tmr_d;
    logic             s_rdy_q, s_rdy_d;
    logic [IN_W-1:0]  acc_in_dat_q, acc_in_dat_d;
    logic             acc_in_vld_q, acc_in_vld_d;
    logic             w_vld_q, w_vld_d;
    logic [OUT_W-1:0] m_dat_q, m_dat_d;
    logic             m_vld_q, m_vld_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             terr_q, terr_d;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= IDLE;
            num_q        <= '0;
            cnt_q        <= '0;
            cfg_cnt_q    <= '0;
            tmr_q        <= '0;
            s_rdy_q      <= 1'b0;
            acc_in_dat_q <= '0;
            acc_in_vld_q <= 1'b0;
            w_vld_q      <= 1'b0;
            m_dat_q      <= '0;
            m_vld_q      <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            terr_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            num_q        <= num_d;
            cnt_q        <= cnt_d;
            cfg_cnt_q    <= cfg_cnt_d;
            tmr_q        <= tmr_d;
            s_rdy_q      <= s_rdy_d;
            acc_in_dat_q <= acc_in_dat_d;
            acc_in_vld_q <= acc_in_vld_d;
            w_vld_q      <= w_vld_d;
            m_dat_q      <= m_dat_d;
            m_vld_q      <= m_vld_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            terr_q       <= terr_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        num_d        = num_q;
        cnt_d        = cnt_q;
        cfg_cnt_d    = cfg_cnt_q;
        tmr_d        = tmr_q;
        s_rdy_d      = s_rdy_q;
        acc_in_dat_d = acc_in_dat_q;
        acc_in_vld_d = 1'b0;
        w_vld_d      = w_vld_q;
        m_dat_d      = m_dat_q;
        m_vld_d      = m_vld_q;
        busy_d       = busy_q;
        done_d       = 1'b0;
        terr_d       = terr_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d   = CFG;
                    num_d     = num_samples;
                    cnt_d     = '0;
                    terr_d    = 1'b0;
                    cfg_cnt_d = CFG_LAST;
                    w_vld_d   = 1'b1;
                    busy_d    = 1'b1;
                end
            end
            CFG: begin
                if (cfg_cnt_q == '0) begin
                    if (num_q == 16'd0) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                        w_vld_d = 1'b0;
                        busy_d  = 1'b0;
                    end else begin
                        state_d = LOAD;
                        s_rdy_d = 1'b1;
                    end
                end else begin
                    cfg_cnt_d = cfg_cnt_q - 1'b1;
                end
            end
            LOAD: begin
                if (s_vld && s_rdy_q) begin
                    state_d      = WAIT;
                    acc_in_dat_d = s_dat;
                    acc_in_vld_d = 1'b1;
                    s_rdy_d      = 1'b0;
                    tmr_d        = '0;
                end
            end
            WAIT: begin
                // A result arriving on the final timer cycle still counts.
                if (acc_out_vld) begin
                    state_d = HOLD;
                    m_dat_d = acc_out_dat;
                    m_vld_d = 1'b1;
                end else if (tmr_q == TMR_LAST) begin
                    state_d = IDLE;
                    terr_d  = 1'b1;
                    done_d  = 1'b1;
                    w_vld_d = 1'b0;
                    busy_d  = 1'b0;
                end else begin
                    tmr_d = tmr_q + 1'b1;
                end
            end
            HOLD: begin
                if (m_rdy) begin
                    m_vld_d = 1'b0;
                    cnt_d   = cnt_q + 16'd1;
                    if (cnt_d == num_q) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                        w_vld_d = 1'b0;
                        busy_d  = 1'b0;
                    end else begin
                        state_d = LOAD;
                        s_rdy_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign s_rdy       = s_rdy_q;
    assign acc_in_dat  = acc_in_dat_q;
    assign acc_in_vld  = acc_in_vld_q;
    assign w_vld       = w_vld_q;
    assign m_dat       = m_dat_q;
    assign m_vld       = m_vld_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign timeout_err = terr_q;
    assign sample_cnt  = cnt_q;

endmodule

// File: tb/tb_econ_run_seq.sv
// Directed bench for econ_run_seq: inputs driven and outputs checked on the falling edge.
module tb_econ_run_seq;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [15:0]  num_samples;
    logic [383:0] s_dat;
    logic         s_vld;
    logic         s_rdy;
    logic [383:0] acc_in_dat;
    logic         acc_in_vld;
    logic         w_vld;
    logic [79:0]  acc_out_dat;
    logic         acc_out_vld;
    logic [79:0]  m_dat;
    logic         m_vld;
    logic         m_rdy;
    logic         busy;
    logic         done;
    logic         timeout_err;
    logic [15:0]  sample_cnt;

    int total = 0;
    int bad   = 0;

    econ_run_seq dut (
        .clk(clk), .rst(rst), .start(start), .num_samples(num_samples),
        .s_dat(s_dat), .s_vld(s_vld), .s_rdy(s_rdy),
        .acc_in_dat(acc_in_dat), .acc_in_vld(acc_in_vld), .w_vld(w_vld),
        .acc_out_dat(acc_out_dat), .acc_out_vld(acc_out_vld),
        .m_dat(m_dat), .m_vld(m_vld), .m_rdy(m_rdy),
        .busy(busy), .done(done), .timeout_err(timeout_err), .sample_cnt(sample_cnt)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [383:0] obs, input logic [383:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, ".s_rdy"}, s_rdy, 0);
        chk({tag, ".acc_in_vld"}, acc_in_vld, 0);
        chk({tag, ".acc_in_dat"}, acc_in_dat, 0);
        chk({tag, ".w_vld"}, w_vld, 0);
        chk({tag, ".m_vld"}, m_vld, 0);
        chk({tag, ".m_dat"}, m_dat, 0);
        chk({tag, ".busy"}, busy, 0);
        chk({tag, ".done"}, done, 0);
        chk({tag, ".timeout_err"}, timeout_err, 0);
        chk({tag, ".sample_cnt"}, sample_cnt, 0);
    endtask

    // Starts a run from IDLE; returns at the falling edge of the first LOAD cycle.
    task automatic start_run(input logic [15:0] n);
        start = 1'b1;
        num_samples = n;
        step();
        start = 1'b0;
        chk("cfg1.w_vld", w_vld, 1);
        chk("cfg1.busy", busy, 1);
        chk("cfg1.sample_cnt", sample_cnt, 0);
        chk("cfg1.timeout_err", timeout_err, 0);
        step();
        chk("cfg2.w_vld", w_vld, 1);
        chk("cfg2.s_rdy", s_rdy, 0);
        step();
    endtask

    // One sample from LOAD through downstream handshake; the accelerator answers
    // one cycle after the acc_in_vld pulse.
    task automatic run_sample(input logic [383:0] d, input logic [79:0] r);
        chk("load.s_rdy", s_rdy, 1);
        s_dat = d;
        s_vld = 1'b1;
        m_rdy = 1'b1;
        step();
        s_vld = 1'b0;
        chk("wait0.acc_in_vld", acc_in_vld, 1);
        chk("wait0.acc_in_dat", acc_in_dat, d);
        chk("wait0.s_rdy", s_rdy, 0);
        step();
        chk("wait1.acc_in_vld", acc_in_vld, 0);
        acc_out_vld = 1'b1;
        acc_out_dat = r;
        step();
        acc_out_vld = 1'b0;
        chk("hold.m_vld", m_vld, 1);
        chk("hold.m_dat", m_dat, r);
        step();
        chk("post.m_vld", m_vld, 0);
        chk("post.acc_in_dat", acc_in_dat, d);
    endtask

    initial begin
        logic [383:0] d;
        logic [79:0]  r;

        rst = 1'b0;
        start = 1'b1;
        num_samples = 16'd5;
        s_dat = '0;
        s_vld = 1'b1;
        acc_out_dat = '0;
        acc_out_vld = 1'b1;
        m_rdy = 1'b1;
        step();
        step();
        chk_zero("reset");
        rst = 1'b1;
        start = 1'b0;
        s_vld = 1'b0;
        acc_out_vld = 1'b0;
        step();
        chk("idle.busy", busy, 0);

        // Three samples, prompt accelerator
        start_run(16'd3);
        for (int i = 0; i < 3; i++) begin
            d = {12{32'hA000_0000 + 32'(i)}};
            r = {5{16'h5100 + 16'(i)}};
            run_sample(d, r);
            chk("t1.sample_cnt", sample_cnt, i + 1);
            if (i < 2) chk("t1.done_mid", done, 0);
        end
        chk("t1.done", done, 1);
        chk("t1.busy", busy, 0);
        chk("t1.w_vld", w_vld, 0);
        step();
        chk("t1.done_clear", done, 0);
        chk("t1.cnt_hold", sample_cnt, 3);

        // Zero-sample run
        start_run(16'd0);
        chk("t2.done", done, 1);
        chk("t2.w_vld", w_vld, 0);
        chk("t2.s_rdy", s_rdy, 0);
        chk("t2.sample_cnt", sample_cnt, 0);
        step();
        chk("t2.done_clear", done, 0);

        // Accelerator never answers
        start_run(16'd2);
        chk("t3.s_rdy", s_rdy, 1);
        s_dat = {12{32'hC0DE_0001}};
        s_vld = 1'b1;
        for (int k = 0; k < 64; k++) begin
            step();
            s_vld = 1'b0;
            chk("t3.wait_busy", busy, 1);
            chk("t3.wait_m_vld", m_vld, 0);
            chk("t3.wait_done", done, 0);
        end
        step();
        chk("t3.done", done, 1);
        chk("t3.timeout_err", timeout_err, 1);
        chk("t3.sample_cnt", sample_cnt, 0);
        chk("t3.m_vld", m_vld, 0);
        chk("t3.w_vld", w_vld, 0);
        step();
        chk("t3.done_clear", done, 0);
        chk("t3.terr_sticky", timeout_err, 1);

        // Answer on the last timer cycle, then downstream stalls 10 cycles
        m_rdy = 1'b0;
        start_run(16'd1);
        s_dat = {12{32'h1234_5678}};
        s_vld = 1'b1;
        step();
        s_vld = 1'b0;
        for (int k = 1; k < 64; k++) step();
        chk("t4.busy_last", busy, 1);
        acc_out_vld = 1'b1;
        acc_out_dat = 80'hFEED_BEEF_0000_1111_2222;
        step();
        acc_out_vld = 1'b0;
        for (int k = 0; k < 10; k++) begin
            chk("t4.m_vld", m_vld, 1);
            chk("t4.m_dat", m_dat, 80'hFEED_BEEF_0000_1111_2222);
            chk("t4.s_rdy", s_rdy, 0);
            chk("t4.sample_cnt", sample_cnt, 0);
            chk("t4.timeout_err", timeout_err, 0);
            step();
        end
        m_rdy = 1'b1;
        step();
        chk("t4.done", done, 1);
        chk("t4.sample_cnt_hs", sample_cnt, 1);
        chk("t4.m_vld_hs", m_vld, 0);
        chk("t4.terr_final", timeout_err, 0);
        step();

        // Reset in WAIT, late answer must be ignored
        start_run(16'd2);
        s_dat = {12{32'h7777_0000}};
        s_vld = 1'b1;
        step();
        s_vld = 1'b0;
        chk("t5.acc_in_vld", acc_in_vld, 1);
        step();
        rst = 1'b0;
        step();
        rst = 1'b1;
        chk_zero("t5.rst");
        acc_out_vld = 1'b1;
        acc_out_dat = 80'h1;
        step();
        acc_out_vld = 1'b0;
        chk_zero("t5.after");
        step();
        chk("t5.m_vld", m_vld, 0);
        chk("t5.done", done, 0);

        // Stray start and accelerator result during a run
        start_run(16'd2);
        s_vld = 1'b0;
        start = 1'b1;
        num_samples = 16'd5;
        acc_out_vld = 1'b1;
        acc_out_dat = 80'hBAD;
        step();
        start = 1'b0;
        acc_out_vld = 1'b0;
        chk("t6.m_vld", m_vld, 0);
        chk("t6.busy", busy, 1);
        chk("t6.sample_cnt", sample_cnt, 0);
        run_sample({12{32'h0600_0001}}, 80'h61);
        chk("t6.cnt1", sample_cnt, 1);
        chk("t6.done_mid", done, 0);
        run_sample({12{32'h0600_0002}}, 80'h62);
        chk("t6.cnt2", sample_cnt, 2);
        chk("t6.done", done, 1);
        step();
        chk("t6.done_clear", done, 0);
        chk("t6.busy_end", busy, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/econ_run_seq.md
ECON_RUN_SEQ -- requirements
Module: econ_run_seq

Interface
REQ-001 Parameter IN_W, default 384, width of one input feature vector.
REQ-002 Parameter OUT_W, default 80, width of one accelerator result.
REQ-003 Parameter CFG_CYCLES, default 2, weight-settle cycles before the first sample.
REQ-004 Parameter TIMEOUT, default 64, max cycles waited for an accelerator result.
REQ-005 Ports (name direction width meaning) SHALL be:
 clk  in  1  single clock, all logic on rising edge.
 rst  in  1  reset, synchronous, active-low.
 start  in  1  begin a run, sampled in IDLE only.
 num_samples  in  16  samples in the run, latched at start.
 s_dat  in  IN_W  upstream feature vector.
 s_vld  in  1  upstream valid.
 s_rdy  out  1  upstream ready.
 acc_in_dat  out  IN_W  to accelerator input data.
 acc_in_vld  out  1  to accelerator input valid.
 w_vld  out  1  common valid for all four weight/bias ports of the accelerator.
 acc_out_dat  in  OUT_W  accelerator result data.
 acc_out_vld  in  1  accelerator result valid.
 m_dat  out  OUT_W  downstream result.
 m_vld  out  1  downstream valid.
 m_rdy  in  1  downstream ready.
 busy  out  1  high whenever state is not IDLE.
 done  out  1  one-cycle end-of-run pulse.
 timeout_err  out  1  sticky timeout flag.
 sample_cnt  out  16  results delivered in current/last run.

Function
REQ-006 FSM states SHALL be IDLE, CFG, LOAD, WAIT, HOLD; all outputs registered.
REQ-007 IDLE: start=1 -> CFG next cycle; latch num_samples; clear sample_cnt and timeout_err.
REQ-008 w_vld SHALL be 1 in CFG, LOAD, WAIT, HOLD and 0 in IDLE.
REQ-009 CFG SHALL last exactly CFG_CYCLES cycles, then -> LOAD, or -> IDLE with done if latched num_samples==0.
REQ-010 s_rdy SHALL be 1 only in LOAD; s_vld&s_rdy captures s_dat into acc_in_dat, -> WAIT.
REQ-011 acc_in_vld SHALL be a single-cycle pulse in the first WAIT cycle (handshake at cycle N -> pulse at N+1).
REQ-012 acc_in_dat SHALL hold its value until the next capture.
REQ-013 WAIT: timer cleared on entry, +1 per cycle; acc_out_vld=1 -> capture acc_out_dat into m_dat, m_vld=1 next cycle, -> HOLD.
REQ-014 WAIT: timer reaching TIMEOUT-1 without acc_out_vld -> timeout_err=1, done pulse, -> IDLE; acc_out_vld on that same cycle wins (no timeout).
REQ-015 acc_out_vld outside WAIT SHALL be ignored.
REQ-016 HOLD: m_vld and m_dat stable until m_rdy=1; on handshake m_vld=0, sample_cnt+1.
REQ-017 After HOLD handshake: if new sample_cnt==num_samples -> IDLE with done pulse, else -> LOAD.
REQ-018 done SHALL be high exactly one cycle, the first IDLE cycle after run end.
REQ-019 start while busy SHALL be ignored; num_samples changes after latch SHALL have no effect.
REQ-020 sample_cnt and timeout_err SHALL hold after run end until next accepted start.
REQ-021 num_samples=65535 SHALL complete without wrap; sample_cnt never wraps within a run.

Reset
REQ-022 rst=0 at a rising edge SHALL force IDLE and zero all outputs (s_rdy, acc_in_vld, acc_in_dat, w_vld, m_vld, m_dat, busy, done, timeout_err, sample_cnt) on that edge.
REQ-023 Reset mid-run SHALL discard the in-flight sample/result with no done pulse; a later acc_out_vld SHALL be ignored.
REQ-024 rst=0 SHALL override start and all handshakes asserted on the same edge.

Verification
REQ-025 num_samples=3, s_vld=1, m_rdy=1, accelerator answers 1 cycle after acc_in_vld -> three acc_in_vld pulses, three m_vld beats matching results, sample_cnt=3, one done pulse, w_vld low after.
REQ-026 num_samples=0 -> w_vld high for CFG_CYCLES=2 cycles, no s_rdy, done one cycle later, sample_cnt=0.
REQ-027 num_samples=2, accelerator never answers -> timeout_err=1 after 64 WAIT cycles, done pulse, sample_cnt=0, m_vld never asserted.
REQ-028 m_rdy held low 10 cycles -> m_vld/m_dat stable all 10 cycles, s_rdy stays 0, sample_cnt increments only at handshake.
REQ-029 rst=0 during WAIT, accelerator answers after reset release -> all outputs 0, no m_vld, no done, state IDLE.
REQ-030 start pulsed during a run, acc_out_vld pulsed in LOAD -> both ignored, run completes with expected count.
